dunit_mem_dumper: RTL and testbench

- Debug-unit reader for the data memory in the MEM stage.
- On command, walks a range of word addresses through the MEM debug read port (dunit read-enable/address in, memory word out).
- Serialises each 32-bit word into bytes on a valid/ready stream toward the UART transmitter.
- Used while the CPU is halted to dump data memory to the host.

---
 rtl/dunit_mem_dumper_if.sv | 32 +++
 rtl/dunit_mem_dumper.sv | 147 ++++++++++++++
 tb/tb_dunit_mem_dumper.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/dunit_mem_dumper_if.sv
// Debug-unit bus bundle: MEM debug read port plus the byte stream toward the UART transmitter.
// The master side is the dumper; the slave side is the MEM stage / transmitter pair.
interface dunit_mem_dumper_if #(
  parameter int unsigned NB_WIDTH = 32,
  parameter int unsigned NB_ADDR  = 9,
  parameter int unsigned NB_BYTE  = 8
);
  logic                dunit_r_data;
  logic [NB_ADDR-1:0]  dunit_addr_data;
  logic [NB_WIDTH-1:0] dunit_mem_data;
  logic [NB_BYTE-1:0]  tx_data;
  logic                tx_valid;
  logic                tx_ready;

  modport master (
    output dunit_r_data,
    output dunit_addr_data,
    input  dunit_mem_data,
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  dunit_r_data,
    input  dunit_addr_data,
    output dunit_mem_data,
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/dunit_mem_dumper.sv
// Walks a word range of data memory through the MEM debug port and streams each word
// out as bytes, MSB first, on a valid/ready interface. All outputs are registered.
module dunit_mem_dumper #(
  parameter int unsigned NB_WIDTH = 32,
  parameter int unsigned NB_ADDR  = 9,
  parameter int unsigned NB_BYTE  = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [NB_ADDR-1:0] i_base_addr,
  input  logic [NB_ADDR-2:0] i_word_count,
  dunit_mem_dumper_if.master bus,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [2:0] {StIdle, StRead, StSend, StNext, StDone} state_e;

  localparam logic [NB_ADDR-2:0] RemOne  = (NB_ADDR-1)'(1);
  localparam logic [NB_ADDR-1:0] AddrInc = NB_ADDR'(4);
  localparam logic [NB_ADDR-1:0] AlignMk = ~NB_ADDR'(3);

  state_e state_q, state_d;

  logic [NB_ADDR-1:0]  addr_q, addr_d;
  logic [NB_ADDR-2:0]  remaining_q, remaining_d;
  logic [NB_WIDTH-1:0] word_q, word_d;
  logic [1:0]          byte_idx_q, byte_idx_d;

  logic               r_data_q, r_data_d;
  logic [NB_ADDR-1:0] addr_out_q, addr_out_d;
  logic [NB_BYTE-1:0] tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               start_ok;
  logic               xfer;
  logic [NB_BYTE-1:0] sel_byte;

  assign start_ok = i_start && !i_abort;
  assign xfer     = tx_valid_q && bus.tx_ready;

  // State register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every non-idle transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start_ok) state_d = (i_word_count != '0) ? StRead : StDone;
      StRead: state_d = StSend;
      StSend: if (xfer && byte_idx_q == 2'd0) state_d = StNext;
      StNext: state_d = (remaining_q == RemOne) ? StDone : StRead;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (i_abort && state_q != StIdle) state_d = StIdle;
  end

  // Datapath and registered-output next values
  always_comb begin
    addr_d      = addr_q;
    remaining_d = remaining_q;
    word_d      = word_q;
    byte_idx_d  = byte_idx_q;
    unique case (state_q)
      StIdle: begin
        if (start_ok && i_word_count != '0) begin
          addr_d      = i_base_addr & AlignMk;
          remaining_d = i_word_count;
        end
      end
      StRead: begin
        word_d     = bus.dunit_mem_data;
        byte_idx_d = 2'd3;
      end
      StSend: begin
        if (xfer && byte_idx_q != 2'd0) byte_idx_d = byte_idx_q - 2'd1;
      end
      StNext: begin
        if (remaining_q != RemOne) begin
          remaining_d = remaining_q - RemOne;
          addr_d      = addr_q + AddrInc;
        end
      end
      default: ;
    endcase

    unique case (byte_idx_d)
      2'd3:    sel_byte = word_d[3*NB_BYTE +: NB_BYTE];
      2'd2:    sel_byte = word_d[2*NB_BYTE +: NB_BYTE];
      2'd1:    sel_byte = word_d[1*NB_BYTE +: NB_BYTE];
      default: sel_byte = word_d[0 +: NB_BYTE];
    endcase

    // Outputs are computed from the next state so they line up with it after the edge
    r_data_d   = (state_d == StRead);
    addr_out_d = addr_d;
    tx_valid_d = (state_d == StSend);
    tx_data_d  = tx_valid_d ? sel_byte : tx_data_q;
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StDone);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      addr_q      <= '0;
      remaining_q <= '0;
      word_q      <= '0;
      byte_idx_q  <= '0;
      r_data_q    <= 1'b0;
      addr_out_q  <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      word_q      <= word_d;
      byte_idx_q  <= byte_idx_d;
      r_data_q    <= r_data_d;
      addr_out_q  <= addr_out_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.dunit_r_data    = r_data_q;
  assign bus.dunit_addr_data = addr_out_q;
  assign bus.tx_data         = tx_data_q;
  assign bus.tx_valid        = tx_valid_q;
  assign o_busy              = busy_q;
  assign o_done              = done_q;

endmodule

// File: tb/tb_dunit_mem_dumper.sv
// Bench for dunit_mem_dumper: directed table, reset/abort sequences and random dumps
// checked against a word-list memory model.
module tb_dunit_mem_dumper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [8:0] base = '0;
  logic [7:0] count = '0;
  logic       busy;
  logic       done;

  logic [31:0] mem [128];

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_b[$];
  logic [7:0] got_b[$];
  logic [8:0] exp_a[$];
  logic [8:0] got_a[$];

  typedef struct {
    logic [8:0] base;
    logic [7:0] count;
    int         ready_mode;   // 0: always 1, 1: 1,0,0 repeating, 2: random
    int         abort_after;  // abort while this many bytes have been taken; -1 = never
    int         exp_bytes;
    int         exp_done;
  } vec_t;

  always #5 clk = ~clk;

  dunit_mem_dumper_if #(.NB_WIDTH(32), .NB_ADDR(9), .NB_BYTE(8)) bus ();

  assign bus.dunit_mem_data = mem[bus.dunit_addr_data[8:2]];

  dunit_mem_dumper #(.NB_WIDTH(32), .NB_ADDR(9), .NB_BYTE(8)) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_start      (start),
    .i_abort      (abort),
    .i_base_addr  (base),
    .i_word_count (count),
    .bus          (bus),
    .o_busy       (busy),
    .o_done       (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected dump: consecutive aligned words from base, wrapping in the 512-byte space
  task automatic build_model(input logic [8:0] b, input logic [7:0] n);
    logic [8:0]  a;
    logic [31:0] w;
    exp_b.delete();
    exp_a.delete();
    a = {b[8:2], 2'b00};
    for (int k = 0; k < int'(n); k++) begin
      exp_a.push_back(a);
      w = mem[a / 4];
      exp_b.push_back(w[31:24]);
      exp_b.push_back(w[23:16]);
      exp_b.push_back(w[15:8]);
      exp_b.push_back(w[7:0]);
      a = 9'((int'(a) + 4) % 512);
    end
  endtask

  task automatic run_dump(input vec_t v);
    int         c;
    int         done_cnt;
    int         done_cyc;
    int         abort_cyc;
    bit         fin;
    bit         prev_stall;
    logic [7:0] prev_data;
    build_model(v.base, v.count);
    got_b.delete();
    got_a.delete();
    c = 0; done_cnt = 0; done_cyc = -1; abort_cyc = -1; fin = 0; prev_stall = 0;
    prev_data = '0;
    @(negedge clk);
    base = v.base;
    count = v.count;
    start = 1'b1;
    while (!fin && c < 2000) begin
      @(negedge clk);
      c++;
      // Inputs change after the start edge; the latched values must be unaffected
      base = ~v.base;
      count = v.count + 8'd5;
      start = (c == 3);
      case (v.ready_mode)
        0:       bus.tx_ready = 1'b1;
        1:       bus.tx_ready = (c % 3 == 2);
        default: bus.tx_ready = 1'($urandom_range(0, 1));
      endcase
      abort = 1'b0;
      if (v.abort_after >= 0 && abort_cyc < 0 && bus.tx_valid &&
          got_b.size() == v.abort_after) begin
        abort = 1'b1;
        bus.tx_ready = 1'b0;
        abort_cyc = c;
      end
      if (prev_stall) begin
        check("hold_valid", 32'(bus.tx_valid), 32'd1);
        check("hold_data", 32'(bus.tx_data), 32'(prev_data));
      end
      prev_stall = bus.tx_valid && !bus.tx_ready && !abort;
      prev_data = bus.tx_data;
      if (bus.dunit_r_data) got_a.push_back(bus.dunit_addr_data);
      if (bus.tx_valid && bus.tx_ready) got_b.push_back(bus.tx_data);
      if (done) begin
        done_cnt++;
        done_cyc = c;
        check("busy_with_done", 32'(busy), 32'd1);
      end else if (done_cyc >= 0 && c == done_cyc + 1) begin
        check("busy_after_done", 32'(busy), 32'd0);
        fin = 1;
      end
      if (abort_cyc >= 0 && c == abort_cyc + 1) begin
        check("abort_valid", 32'(bus.tx_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rdata", 32'(bus.dunit_r_data), 32'd0);
      end
      if (abort_cyc >= 0 && c == abort_cyc + 8) fin = 1;
    end
    start = 1'b0;
    abort = 1'b0;
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no completion after %0d cycles, required completion", c);
    end
    check("n_bytes", 32'(got_b.size()), 32'(v.exp_bytes));
    for (int i = 0; i < got_b.size() && i < exp_b.size(); i++)
      check($sformatf("byte%0d", i), 32'(got_b[i]), 32'(exp_b[i]));
    if (v.abort_after < 0) begin
      check("n_reads", 32'(got_a.size()), 32'(exp_a.size()));
      for (int i = 0; i < got_a.size() && i < exp_a.size(); i++)
        check($sformatf("addr%0d", i), 32'(got_a[i]), 32'(exp_a[i]));
    end else if (got_a.size() > 0) begin
      check("addr0", 32'(got_a[0]), 32'(exp_a[0]));
    end
    check("done_count", 32'(done_cnt), 32'(v.exp_done));
    if (v.exp_done != 0 && v.ready_mode == 0)
      check("done_cycle", 32'(done_cyc), 32'(1 + 6 * int'(v.count)));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rdata"}, 32'(bus.dunit_r_data), 32'd0);
    check({tag, "_addr"}, 32'(bus.dunit_addr_data), 32'd0);
    check({tag, "_txdata"}, 32'(bus.tx_data), 32'd0);
    check({tag, "_valid"}, 32'(bus.tx_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic load_directed();
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    mem[9'h010 / 4] = 32'hDEADBEEF;
    mem[9'h014 / 4] = 32'h01234567;
    mem[9'h1FC / 4] = 32'hAABBCCDD;
    mem[0]          = 32'h11223344;
  endtask

  vec_t tbl[8];
  vec_t rv;

  initial begin
    bus.tx_ready = 1'b0;
    load_directed();
    tbl[0] = '{9'h010, 8'd2, 0, -1, 8, 1};   // basic two-word dump
    tbl[1] = '{9'h010, 8'd2, 1, -1, 8, 1};   // back-pressure
    tbl[2] = '{9'h1FC, 8'd2, 0, -1, 8, 1};   // address wrap
    tbl[3] = '{9'h013, 8'd1, 0, -1, 4, 1};   // unaligned base
    tbl[4] = '{9'h000, 8'd0, 0, -1, 0, 1};   // empty dump
    tbl[5] = '{9'h010, 8'd2, 0, 1, 1, 0};    // abort with second byte pending
    tbl[6] = '{9'h010, 8'd2, 0, -1, 8, 1};   // fresh start after abort
    tbl[7] = '{9'h020, 8'd3, 2, -1, 12, 1};  // random ready

    #3;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_dump(tbl[i]);

    // Reset during SEND of the first word, then restart from a new base
    @(negedge clk);
    base = 9'h010;
    count = 8'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus.tx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_valid", 32'(bus.tx_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    rv = '{9'h014, 8'd1, 0, -1, 4, 1};
    run_dump(rv);

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 128; i++) mem[i] = $urandom;
      rv.base = 9'($urandom);
      rv.count = 8'($urandom_range(0, 4));
      rv.ready_mode = (r % 2 == 0) ? 0 : 2;
      rv.abort_after = -1;
      rv.exp_bytes = 4 * int'(rv.count);
      rv.exp_done = 1;
      run_dump(rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
